// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - multicycle MIPS control FSM with memory stall handshake (optional ILLEGAL_OP_TRAP_EN)
module mips_controller #(
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       regwrite,
    output logic       irwrite,
    output logic       memread,
    output logic       memwrite,
    output logic [2:0] alucontrol,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur;
    logic [2:0] funct_alu;
    logic       funct_legal;
    logic       wait_state;
    logic [7:0] stall_cnt;
    logic [8:0] stall_inc;

    // funct to ALU operation; unknown funct falls back to ADD and is flagged illegal
    always_comb begin
        funct_alu   = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000000: funct_alu = ALU_SLL;
            6'b000010: funct_alu = ALU_SRL;
            default:   funct_legal = 1'b0;
        endcase
    end

    // state sequencing; memory states hold until mem_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:  cur <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYPE:     cur <= S_RTYPEEX;
                        OP_BEQ:       cur <= S_BEQEX;
                        OP_ADDI:      cur <= S_ADDIEX;
                        OP_J:         cur <= S_JEX;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:      cur <= S_HALT;
`else
                        default:      cur <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:  cur <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   cur <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   cur <= S_FETCH;
                S_MEMWR:   cur <= mem_ready ? S_FETCH : S_MEMWR;
`ifdef ILLEGAL_OP_TRAP_EN
                S_RTYPEEX: cur <= funct_legal ? S_RTYPEWB : S_HALT;
`else
                S_RTYPEEX: cur <= S_RTYPEWB;
`endif
                S_RTYPEWB: cur <= S_FETCH;
                S_BEQEX:   cur <= S_FETCH;
                S_ADDIEX:  cur <= S_ADDIWB;
                S_ADDIWB:  cur <= S_FETCH;
                S_JEX:     cur <= S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                S_HALT:    cur <= S_HALT;
`endif
                default:   cur <= S_FETCH;
            endcase
        end
    end

    assign wait_state = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    assign stall_inc  = {1'b0, stall_cnt} + 9'd1;

    // per-wait stall counter with sticky timeout flag; the FSM never aborts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= 8'd0;
            mem_timeout <= 1'b0;
        end else if (wait_state && !mem_ready) begin
            if (stall_cnt != 8'hff) begin
                stall_cnt <= stall_inc[7:0];
            end
            if (stall_inc >= 9'(MEM_WAIT_MAX)) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            stall_cnt <= 8'd0;
        end
    end

    // control strobes decoded from state; fetch/branch enables gated by live inputs
    always_comb begin
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcen       = 1'b0;
        pcsource   = 2'b00;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        regwrite   = 1'b0;
        irwrite    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        alucontrol = 3'b000;
        case (cur)
            S_FETCH: begin
                iord       = 1'b1;
                memread    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready;
                pcen       = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD:   memread = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR:   memwrite = 1'b1;
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsource   = 2'b01;
                pcen       = zero;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JEX: begin
                pcsource = 2'b10;
                pcen     = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcen       = 1'b0;
            pcsource   = 2'b00;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            iord       = 1'b0;
            regwrite   = 1'b0;
            irwrite    = 1'b0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            alucontrol = 3'b000;
        end
    end

    assign state = reset ? cur : S_FETCH;

endmodule
